// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial adder sequencer.
package serial_adder_pkg;

  // Default operand/result width in bits (legal range 2..32)
  localparam int DEFAULT_WIDTH = 8;

  // Controller state encoding; code 2'd3 is unused and recovers to IDLE
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester and the serial adder.
interface serial_adder_ctrl_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Requester side: issues operands and start, observes status and result
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  // Adder side: accepts operands, produces status and result
  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder_ctrl_fa_cell.sv
// One-bit full adder built from two NAND half adders and a carry merge.

// Half adder made only of NAND gates
module nand_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  logic n_ab;
  logic n_a;
  logic n_b;

  // NAND-only XOR for the sum and inverted NAND for the carry
  always_comb begin
    n_ab = ~(a & b);
    n_a  = ~(a & n_ab);
    n_b  = ~(b & n_ab);
    s    = ~(n_a & n_b);
    c    = ~n_ab;
  end

endmodule

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  nand_ha u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
  nand_ha u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

  // The two half-adder carries can never both be set, so OR merges them
  always_comb begin
    co = c1 | c2;
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder cell, LSB first,
// with a registered carry chaining the bit positions.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_ctrl_if.slave bus
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             cell_s;
  logic             cell_co;

  fa_cell u_cell (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (carry),
    .s  (cell_s),
    .co (cell_co)
  );

  // New sum bit enters at the MSB so after WIDTH shifts sr holds the result
  always_comb begin
    sr_next = {cell_s, sr[WIDTH-1:1]};
  end

  // Status flags decode directly from the state register
  always_comb begin
    bus.busy = (state == S_RUN);
    bus.done = (state == S_DONE);
  end

  // Controller, counter, shift registers and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            sa    <= bus.a;
            sb    <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          sr    <= sr_next;
          carry <= cell_co;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            bus.sum  <= sr_next;
            bus.cout <= cell_co;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   numChecks;
  int   numFails;

  serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse start for one cycle with the given operands; returns after the
  // accepting edge, at the following falling edge
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic cv);
    @(negedge clk);
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = cv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Full operation: checks busy length, done pulse width and the result
  task automatic runOp(input string tag, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input logic cv,
                       input logic [WIDTH-1:0] expSum, input logic expCout);
    int busyCycles;
    bit gotDone;
    busyCycles = 0;
    gotDone    = 1'b0;
    applyStimulus(av, bv, cv);
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        gotDone = 1'b1;
        break;
      end
      if (bus.busy) busyCycles++;
      @(negedge clk);
    end
    checkOutput({tag, " done seen"}, 32'(gotDone), 32'd1);
    checkOutput({tag, " busy cycles"}, 32'(busyCycles), 32'(WIDTH));
    checkOutput({tag, " sum"}, 32'(bus.sum), 32'(expSum));
    checkOutput({tag, " cout"}, 32'(bus.cout), 32'(expCout));
    @(negedge clk);
    checkOutput({tag, " done width"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int doneCount;
    int lastDone;
    int gapErrs;
    bit sumErr;

    numChecks = 0;
    numFails  = 0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset sum",  32'(bus.sum),  32'd0);
    checkOutput("reset cout", 32'(bus.cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    runOp("5A+3C",    8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    runOp("FF+01",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    runOp("FF+FF+1",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    runOp("00+00",    8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    // Second start during RUN is ignored and operand changes have no effect
    applyStimulus(8'h10, 8'h20, 1'b0);
    doneCount = 0;
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    bus.cin   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("ignored start busy", 32'(bus.busy), 32'd1);
    checkOutput("sum held in RUN", 32'(bus.sum), 32'h00);
    for (int i = 0; i < 20; i++) begin
      if (bus.done) doneCount++;
      @(negedge clk);
    end
    checkOutput("ignored start done count", 32'(doneCount), 32'd1);
    checkOutput("ignored start sum", 32'(bus.sum), 32'h30);
    checkOutput("ignored start cout", 32'(bus.cout), 32'd0);
    checkOutput("ignored start idle", 32'(bus.busy), 32'd0);

    // Reset in the middle of an operation discards it
    applyStimulus(8'h77, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset busy", 32'(bus.busy), 32'd0);
    checkOutput("mid reset done", 32'(bus.done), 32'd0);
    checkOutput("mid reset sum",  32'(bus.sum),  32'd0);
    checkOutput("mid reset cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 14; i++) begin
      if (bus.done) doneCount++;
      @(negedge clk);
    end
    checkOutput("no done after reset", 32'(doneCount), 32'd0);
    runOp("after reset 12+34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    // Start held high: one operation every WIDTH+2 cycles
    bus.a     = 8'h01;
    bus.b     = 8'h01;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    doneCount = 0;
    lastDone  = -1;
    gapErrs   = 0;
    sumErr    = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        doneCount++;
        if (lastDone >= 0 && (i - lastDone) != WIDTH + 2) gapErrs++;
        if (bus.sum !== 8'h02 || bus.cout !== 1'b0) sumErr = 1'b1;
        lastDone = i;
      end
    end
    bus.start = 1'b0;
    checkOutput("held start done count", 32'(doneCount), 32'd4);
    checkOutput("held start done spacing errors", 32'(gapErrs), 32'd0);
    checkOutput("held start sum errors", 32'(sumErr), 32'd0);
    checkOutput("held start first done", 32'(lastDone - 3 * (WIDTH + 2)), 32'd9);
    repeat (12) @(negedge clk);
    checkOutput("final idle busy", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial WIDTH-bit adder sequencer. It drives one 1-bit full-adder cell, built from two NAND half adders plus a carry merge, once per clock, LSB first.
- A registered carry flip-flop chains the bit positions.
- Replaces a WIDTH-wide ripple of half/full adders with a single shared cell plus control.
- Sits between a requester (start/operands) and any consumer of sum/cout; provides start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width. Derived; not overridden by users.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse/level; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while the operation is in progress (RUN state)
- done  output  1  one-cycle pulse: sum/cout newly valid
- sum  output  WIDTH  result, registered, held until next completion
- cout  output  1  final carry-out, registered, held until next completion

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and counter all cleared.
  - Operation in flight is discarded; no done is produced for it.
- States: IDLE, RUN, DONE (encoded in a 2-bit register; unused code goes to IDLE).
- IDLE:
  - start=1 at edge E0: capture a, b into shift regs sa, sb; carry flop=cin; cnt=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy=1), at each edge:
  - Full-adder cell inputs: sa[0], sb[0], carry.
  - Cell sum bit shifts into the MSB of the result shift reg sr, with sr shifting right.
  - sa and sb shift right; carry takes the cell carry-out; cnt increments.
  - At the edge where cnt==WIDTH-1: load sum<=final sr, cout<=final carry, and go to DONE.
- DONE: done=1 for exactly one cycle; go unconditionally to IDLE on the next edge.
- Latency, with start accepted at E0:
  - busy high from E0 to EWIDTH.
  - done high between EWIDTH and EWIDTH+1.
  - sum/cout change only at EWIDTH.
  - Total WIDTH+1 cycles from accept to end of done pulse.
- Start handling:
  - start is ignored in RUN and DONE; there is no queueing.
  - Earliest next accept is the edge after the DONE cycle.
  - A start held high continuously yields one operation per WIDTH+2 cycles.
- Operand changes on a/b/cin after accept have no effect on the operation.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned. Overflow is reported only via cout.
- sum/cout are never partially updated; intermediate bits are visible only in internal sr.

Decomposition:
- Package serial_adder_pkg:
  - State localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - Default WIDTH.
- One sub-module, fa_cell: purely combinational 1-bit full adder.
  - Two NAND-based half-adder instances plus an OR of the two carries.
  - Ports a, b, ci, s, co.
- Controller FSM, counter and shift registers live in serial_adder_ctrl.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse -> busy high 8 cycles; done 1 cycle; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (full carry ripple through all bit positions).
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; also a=0, b=0, cin=0 -> sum=0x00, cout=0.
- Accept a=0x10, b=0x20; pulse start again and change a, b during RUN -> second start ignored; sum=0x30; exactly one done.
- Assert rst_n low for 1 cycle at RUN cycle 4 -> busy, done, sum, cout=0 immediately; no done follows; new start then works normally.
- start held high continuously with a=1, b=1, cin=0 -> done pulses every 10 cycles; sum=0x02 each time.
